tdc_disp_stat: RTL and testbench
================================

Name: tdc_disp_stat

Overview:
Statistics/hold stage directly upstream of the six-digit seven-segment hex driver on the CV5 board. Collects TDC edge-timing samples from the CAN PLI capture path and averages them over a fixed window. Publishes the window mean on data1 (12 bit) and a cumulative sample count on data2 (21 bit), both ready to wire straight into the hex driver. Freezes the published values for a hold period so the digits are readable, not flickering.

Parameters:
LOG2_N, 4, log2 of samples per averaging window (window = 2^LOG2_N samples); legal range 1..8
HOLD_CYCLES, 50000000, display hold length in CLK cycles after each publish; must be >= 1 (1 s at 50 MHz)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  reset
tdc_valid  in  1  one-cycle strobe, tdc_value valid this cycle
tdc_value  in  12  TDC measurement, unsigned
clear  in  1  synchronous soft clear, active-high
data1  out  12  window mean, to hex driver data1
data2  out  21  cumulative accepted-sample count (see Optional Feature), to hex driver data2
upd  out  1  one-cycle pulse when data1/data2 change
busy  out  1  high while samples are being ignored (LATCH or HOLD)

Behaviour:
- Interface: one clock, CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N=0 at an edge):
  - data1=0, data2=0, upd=0, busy=0.
  - Internal sum, window count, total count and hold timer all 0.
  - State=ACC.
- clear=1 at an edge: same effect as reset. It has priority over tdc_valid in the same cycle.
- Internal widths:
  - sum is 12+LOG2_N bits and can never overflow.
  - Window counter is LOG2_N+1 bits.
  - Total counter is 21 bits and wraps 0x1FFFFF -> 0 silently.
- State ACC (busy=0):
  - tdc_valid=1: sum += tdc_value, window count +1.
  - When the accepted sample is the 2^LOG2_N-th, next state is LATCH.
  - Otherwise stay in ACC.
- State LATCH (busy=1, exactly one cycle):
  - At the exiting edge: data1 <= sum >> LOG2_N (floor, truncation, no rounding).
  - total += 2^LOG2_N, data2 <= new total.
  - upd <= 1; sum and window count cleared; hold timer loaded with HOLD_CYCLES-1.
  - Next state is HOLD.
- State HOLD (busy=1):
  - upd returns to 0 after one cycle.
  - Timer decrements each cycle; HOLD lasts exactly HOLD_CYCLES cycles, then ACC.
  - tdc_valid is ignored: the sample is not summed and not counted.
- Latency: last sample of the window accepted at edge E0 -> data1/data2 updated and upd=1 after edge E1 -> upd=0 after E2.
- data1/data2 change only at the LATCH edge, or on reset/clear. They are stable otherwise.
- Reset or clear in mid-window or mid-HOLD: the partial window is discarded and the block starts a fresh window in ACC.

Optional Feature:
- Macro: TDC_MAX_TRACK_EN.
- Defined:
  - A 12-bit window maximum register tracks max(tdc_value) over accepted samples and resets with sum.
  - At LATCH, data2 <= {9'b0, window max}; the total counter is not implemented.
  - The hex display then shows mean | max.
- Not defined: data2 = cumulative accepted-sample count as above.

Test Plan:
- Bench parameters: LOG2_N=2, HOLD_CYCLES=8, unless stated.
- Hold RST_N=0 for 3 cycles, release, no stimulus -> data1=0x000, data2=0, upd=0, busy=0 for 20 cycles.
- Samples 100, 200, 300, 401 on non-consecutive cycles -> data1=250 (0x0FA, floor of 1001/4), data2=4, single upd pulse 1 cycle after LATCH, busy high for 9 cycles.
- After the first publish, 5 strobes during HOLD, then 4 samples of 0xFFF -> data1=0xFFF (no overflow), data2=8; the HOLD samples are not counted.
- 2 samples of 50, then clear=1 together with tdc_valid, then 4 samples of 8 -> data1=8, data2=4.
- RST_N=0 mid-HOLD -> next edge: data1=0, data2=0, busy=0; a following window of 4×20 -> data1=20, data2=4.
- TDC_MAX_TRACK_EN defined, samples 5, 9, 3, 7 -> data1=6, data2=9. Separate non-macro build, force total to 0x1FFFFC and run one window -> data2 wraps to 0.

Source files
------------

// File: rtl/tdc_disp_stat.sv
// Windowed TDC mean/count stage feeding the six-digit hex display, with a display hold.
// Build option TDC_MAX_TRACK_EN: data2 shows the window maximum instead of the running sample count.
module tdc_disp_stat #(
  parameter int LOG2_N      = 4,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        tdc_valid,
  input  logic [11:0] tdc_value,
  input  logic        clear,
  output logic [11:0] data1,
  output logic [20:0] data2,
  output logic        upd,
  output logic        busy
);

  localparam int SW = 12 + LOG2_N;
  localparam int CW = LOG2_N + 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG2_N) - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {ACC, LATCH, HOLD} state_t;

  state_t        state, state_next;
  logic [SW-1:0] sum;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
`ifdef TDC_MAX_TRACK_EN
  logic [11:0]   wmax;
`else
  logic [20:0]   total;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N || clear) state <= ACC;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != ACC);
    case (state)
      ACC:     if (tdc_valid && cnt == LAST_IDX) state_next = LATCH;
      LATCH:   state_next = HOLD;
      HOLD:    if (timer == '0) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || clear) begin
      sum   <= '0;
      cnt   <= '0;
      timer <= '0;
      data1 <= '0;
      data2 <= '0;
      upd   <= 1'b0;
`ifdef TDC_MAX_TRACK_EN
      wmax  <= '0;
`else
      total <= '0;
`endif
    end else begin
      upd <= 1'b0;
      case (state)
        ACC: begin
          if (tdc_valid) begin
            sum <= sum + SW'(tdc_value);
            cnt <= cnt + 1'b1;
`ifdef TDC_MAX_TRACK_EN
            if (tdc_value > wmax) wmax <= tdc_value;
`endif
          end
        end
        LATCH: begin
          // Truncating divide: drop the LOG2_N low bits of the window sum.
          data1 <= sum[SW-1:LOG2_N];
`ifdef TDC_MAX_TRACK_EN
          data2 <= {9'b0, wmax};
          wmax  <= '0;
`else
          total <= total + 21'(1 << LOG2_N);
          data2 <= total + 21'(1 << LOG2_N);
`endif
          upd   <= 1'b1;
          sum   <= '0;
          cnt   <= '0;
          timer <= HOLD_LOAD;
        end
        HOLD: begin
          if (timer != '0) timer <= timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_disp_stat.sv
// Directed self-checking bench for tdc_disp_stat (LOG2_N=2, HOLD_CYCLES=8).
module tb_tdc_disp_stat;

  logic        CLK = 1'b0;
  logic        RST_N, tdc_valid, clear;
  logic [11:0] tdc_value;
  logic [11:0] data1;
  logic [20:0] data2;
  logic        upd, busy;

  int n_checks = 0;
  int n_fail   = 0;

  tdc_disp_stat #(.LOG2_N(2), .HOLD_CYCLES(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .tdc_valid(tdc_valid), .tdc_value(tdc_value),
    .clear(clear), .data1(data1), .data2(data2), .upd(upd), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0][11:0] s;
    logic [11:0]      e1;
    logic [20:0]      cnt;
    logic [11:0]      mx;
  } vec_t;

  vec_t tbl[3];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Feed four samples with idle gaps, then follow LATCH/HOLD with strobes that must be ignored.
  task automatic run_window(input logic [3:0][11:0] s, input logic [11:0] e1,
                            input logic [20:0] e2, input string tag);
    int n, ups;
    for (int i = 0; i < 4; i++) begin
      tdc_valid = 1'b1;
      tdc_value = s[i];
      tick();
      tdc_valid = 1'b0;
      if (i < 3) begin
        check({tag, " busy_acc"}, busy, 1'b0);
        tick();
      end
    end
    check({tag, " busy_latch"}, busy, 1'b1);
    check({tag, " upd_early"}, upd, 1'b0);
    n = 0;
    ups = 0;
    while (busy && n < 100) begin
      tdc_valid = ~n[0];
      tdc_value = 12'hABC;
      tick();
      n++;
      if (upd) ups++;
      if (n == 1) begin
        check({tag, " upd_pulse"}, upd, 1'b1);
        check({tag, " data1"}, data1, e1);
        check({tag, " data2"}, data2, e2);
      end
    end
    tdc_valid = 1'b0;
    check({tag, " busy_cycles"}, n, 9);
    check({tag, " upd_count"}, ups, 1);
    check({tag, " data1_held"}, data1, e1);
  endtask

  initial begin
    tbl[0] = '{s: {12'd401, 12'd300, 12'd200, 12'd100}, e1: 12'd250, cnt: 21'd4,  mx: 12'd401};
    tbl[1] = '{s: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, e1: 12'hFFF, cnt: 21'd8,  mx: 12'hFFF};
    tbl[2] = '{s: {12'd7,   12'd3,   12'd9,   12'd5},   e1: 12'd6,   cnt: 21'd12, mx: 12'd9};

    RST_N = 1'b0; clear = 1'b0; tdc_valid = 1'b0; tdc_value = '0;
    repeat (3) tick();
    RST_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("idle data1", data1, 12'h000);
      check("idle data2", data2, 21'd0);
      check("idle upd", upd, 1'b0);
      check("idle busy", busy, 1'b0);
      tick();
    end

    for (int v = 0; v < 3; v++) begin
`ifdef TDC_MAX_TRACK_EN
      run_window(tbl[v].s, tbl[v].e1, {9'b0, tbl[v].mx}, $sformatf("vec%0d", v));
`else
      run_window(tbl[v].s, tbl[v].e1, tbl[v].cnt, $sformatf("vec%0d", v));
`endif
    end

    // Clear together with a strobe: partial window and the strobed sample are dropped.
    for (int i = 0; i < 2; i++) begin
      tdc_valid = 1'b1; tdc_value = 12'd50; tick();
      tdc_valid = 1'b0; tick();
    end
    clear = 1'b1; tdc_valid = 1'b1; tdc_value = 12'd50;
    tick();
    clear = 1'b0; tdc_valid = 1'b0;
    check("clear data1", data1, 12'h000);
    check("clear data2", data2, 21'd0);
    check("clear busy", busy, 1'b0);
`ifdef TDC_MAX_TRACK_EN
    run_window({4{12'd8}}, 12'd8, 21'd8, "after_clear");
`else
    run_window({4{12'd8}}, 12'd8, 21'd4, "after_clear");
`endif

    // Reset arriving mid-HOLD.
    for (int i = 0; i < 4; i++) begin
      tdc_valid = 1'b1; tdc_value = 12'd30; tick();
    end
    tdc_valid = 1'b0;
    tick();
    check("pre_rst data1", data1, 12'd30);
    repeat (3) tick();
    check("pre_rst busy", busy, 1'b1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("rst_hold data1", data1, 12'h000);
    check("rst_hold data2", data2, 21'd0);
    check("rst_hold busy", busy, 1'b0);
    check("rst_hold upd", upd, 1'b0);
`ifdef TDC_MAX_TRACK_EN
    run_window({4{12'd20}}, 12'd20, 21'd20, "after_rst");
`else
    run_window({4{12'd20}}, 12'd20, 21'd4, "after_rst");

    // Total counter wraps from 0x1FFFFC by one window of four.
    force dut.total = 21'h1FFFFC;
    run_window({12'd4, 12'd3, 12'd2, 12'd1}, 12'd2, 21'd0, "wrap");
    release dut.total;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
